mips_wb_trace_buffer: RTL and testbench

Captures every architectural register-file writeback of the single-cycle MIPS core as a (PC, write number, write data) record and queues it in a small FIFO. It sits directly downstream of the core's register-file write port and feeds a valid/ready trace stream to the golden-trace comparator or a host drain port. Capture ends at the core's end-of-test store, a word 0 written to address 12. The block then drains and reports done.

---
 rtl/mips_wb_trace_buffer.sv | 131 +++++++++++++
 tb/tb_mips_wb_trace_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_wb_trace_buffer.sv
// Register-file writeback trace buffer: queues {pc, wnum, wdata} records from the
// single-cycle MIPS core and drains them over a show-ahead valid/ready stream.
module mips_wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        mips_cpu_clk,
    input  logic        mips_cpu_reset,
    input  logic        rf_wen,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    input  logic [31:0] pc,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_wnum,
    output logic [31:0] trace_wdata,
    output logic        trace_done,
    output logic        trace_overflow,
    output logic [31:0] trace_count,
    output logic [15:0] drop_count
);

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [68:0] mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        overflow_r;
    logic [31:0] count_r;
    logic [15:0] drop_r;

    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        event_s;
    logic        end_marker_s;
    logic        push_s;
    logic        drop_s;
    logic [68:0] head_s;

    // Queue status and event qualification; a full queue still accepts when the head leaves this cycle.
    always_comb begin
        empty_s      = (wr_ptr_r == rd_ptr_r);
        full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s        = !empty_s && trace_ready;
        event_s      = rf_wen && (rf_waddr != 5'd0) && (state_r == ST_CAPTURE);
        end_marker_s = mem_write && (mem_write_data == 32'd0) &&
                       (mem_address == 32'd12) && (state_r == ST_CAPTURE);
        push_s       = event_s && (!full_s || pop_s);
        drop_s       = event_s && full_s && !pop_s;
        head_s       = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Next-state logic: DONE is entered from the first DRAIN cycle that starts with an empty queue.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CAPTURE: begin
                if (end_marker_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (empty_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_next_s = ST_DONE;
            default:  state_next_s = ST_CAPTURE;
        endcase
    end

    // State, pointers and statistics.
    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset) begin
            state_r    <= ST_CAPTURE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            overflow_r <= 1'b0;
            count_r    <= 32'd0;
            drop_r     <= 16'd0;
        end else begin
            state_r <= state_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
                count_r  <= count_r + 32'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_r != 16'hFFFF) begin
                    drop_r <= drop_r + 16'd1;
                end
            end
        end
    end

    // Record storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge mips_cpu_clk) begin
        if (!mips_cpu_reset && push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {pc, rf_waddr, rf_wdata};
        end
    end

    assign trace_valid    = !empty_s;
    assign trace_pc       = head_s[68:37];
    assign trace_wnum     = head_s[36:32];
    assign trace_wdata    = head_s[31:0];
    assign trace_done     = (state_r == ST_DONE);
    assign trace_overflow = overflow_r;
    assign trace_count    = count_r;
    assign drop_count     = drop_r;

endmodule

// File: tb/tb_mips_wb_trace_buffer.sv
// Directed/randomized bench for mips_wb_trace_buffer against a queue-based reference model.
module tb_mips_wb_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } rec_t;

    logic        mips_cpu_clk = 1'b0;
    logic        mips_cpu_reset;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
    logic        trace_done;
    logic        trace_overflow;
    logic [31:0] trace_count;
    logic [15:0] drop_count;

    rec_t        q[$];
    logic [31:0] m_count;
    logic [15:0] m_drop;
    logic        m_ovf;
    int          m_phase;   // 0 capturing, 1 draining, 2 finished
    int          pops;
    int          total = 0;
    int          bad = 0;

    mips_wb_trace_buffer #(.DEPTH(16), .AW(4)) dut (
        .mips_cpu_clk   (mips_cpu_clk),
        .mips_cpu_reset (mips_cpu_reset),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .pc             (pc),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_wnum     (trace_wnum),
        .trace_wdata    (trace_wdata),
        .trace_done     (trace_done),
        .trace_overflow (trace_overflow),
        .trace_count    (trace_count),
        .drop_count     (drop_count)
    );

    always #5 mips_cpu_clk = ~mips_cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", {31'd0, trace_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("head_pc", trace_pc, q[0].pc);
            chk("head_wnum", {27'd0, trace_wnum}, {27'd0, q[0].wnum});
            chk("head_wdata", trace_wdata, q[0].wdata);
        end
        chk("count", trace_count, m_count);
        chk("drops", {16'd0, drop_count}, {16'd0, m_drop});
        chk("overflow", {31'd0, trace_overflow}, {31'd0, m_ovf});
        chk("done", {31'd0, trace_done}, {31'd0, m_phase == 2});
    endtask

    task automatic idle();
        rf_wen = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0; pc = 32'd0;
        mem_write = 1'b0; mem_address = 32'd0; mem_write_data = 32'd0;
    endtask

    task automatic rand_write(input logic [4:0] a);
        rf_wen = 1'b1; rf_waddr = a; rf_wdata = $urandom; pc = $urandom;
    endtask

    // One clock: predict from pre-edge inputs, advance the model after the edge, then compare.
    task automatic step();
        logic pop, ev, mk, was_empty;
        rec_t r;
        was_empty = (q.size() == 0);
        pop = !was_empty && trace_ready;
        ev  = rf_wen && (rf_waddr != 5'd0) && (m_phase == 0);
        mk  = mem_write && (mem_write_data == 32'd0) && (mem_address == 32'd12) && (m_phase == 0);
        r   = '{pc: pc, wnum: rf_waddr, wdata: rf_wdata};
        @(posedge mips_cpu_clk);
        #1;
        if (mips_cpu_reset) begin
            q.delete(); m_count = 32'd0; m_drop = 16'd0; m_ovf = 1'b0; m_phase = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (ev) begin
                if (q.size() < DEPTH) begin
                    q.push_back(r);
                    m_count = m_count + 32'd1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
            if (m_phase == 0 && mk) m_phase = 1;
            else if (m_phase == 1 && was_empty) m_phase = 2;
        end
        check_model();
    endtask

    task automatic do_reset();
        idle();
        trace_ready = 1'b0;
        mips_cpu_reset = 1'b1;
        step();
        mips_cpu_reset = 1'b0;
        pops = 0;
    endtask

    initial begin
        q.delete(); m_count = 32'd0; m_drop = 16'd0; m_ovf = 1'b0; m_phase = 0; pops = 0;
        idle();
        trace_ready = 1'b0;
        mips_cpu_reset = 1'b1;
        step();
        step();
        mips_cpu_reset = 1'b0;
        chk("reset_valid", {31'd0, trace_valid}, 32'd0);
        chk("reset_count", trace_count, 32'd0);

        // Basic capture, then a write to $0 that must be ignored
        trace_ready = 1'b1;
        rf_wen = 1'b1; rf_waddr = 5'd8; rf_wdata = 32'h1234; pc = 32'hBFC00000;
        step();
        chk("basic_pc", trace_pc, 32'hBFC00000);
        chk("basic_wdata", trace_wdata, 32'h0000_1234);
        chk("basic_count", trace_count, 32'd1);
        rf_waddr = 5'd0;
        step();
        chk("zero_reg_valid", {31'd0, trace_valid}, 32'd0);
        chk("zero_reg_count", trace_count, 32'd1);

        // Back-pressure: 17 writes into 16 slots, then drain in order
        trace_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            rand_write(5'($urandom_range(31, 1)));
            step();
        end
        idle();
        chk("bp_overflow", {31'd0, trace_overflow}, 32'd1);
        chk("bp_drops", {16'd0, drop_count}, 32'd1);
        chk("bp_count", trace_count, 32'd17);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) step();
        chk("bp_drained", {31'd0, trace_valid}, 32'd0);

        // Full queue with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rand_write(5'($urandom_range(31, 1)));
            step();
        end
        trace_ready = 1'b1;
        rand_write(5'd31);
        step();
        idle();
        chk("full_pp_drops", {16'd0, drop_count}, 32'd0);
        chk("full_pp_count", trace_count, 32'd17);
        for (int i = 0; i < 16; i++) step();

        // Pointer wrap-around: 40 writes with ready toggling
        do_reset();
        for (int i = 0; i < 80; i++) begin
            trace_ready = i[0];
            if (i % 2 == 0) rand_write(5'($urandom_range(31, 1)));
            else idle();
            step();
        end
        idle();
        trace_ready = 1'b1;
        step();
        chk("wrap_count", trace_count, 32'd40);
        chk("wrap_pops", 32'(pops), 32'd40);

        // End of test: 3 queued, marker plus $2 write, later writes ignored
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rand_write(5'($urandom_range(31, 1)));
            step();
        end
        rand_write(5'd2);
        mem_write = 1'b1; mem_address = 32'd12; mem_write_data = 32'd0;
        step();
        mem_write = 1'b0;
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_write(5'($urandom_range(31, 1)));
            step();
        end
        chk("eot_count", trace_count, 32'd4);
        chk("eot_done_after_pop", {31'd0, trace_done}, 32'd0);
        step();
        chk("eot_done", {31'd0, trace_done}, 32'd1);
        step();
        chk("eot_ignored", trace_count, 32'd4);
        idle();

        // Reset mid-drain with 5 queued records
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_write(5'($urandom_range(31, 1)));
            step();
        end
        idle();
        mem_write = 1'b1; mem_address = 32'd12; mem_write_data = 32'd0;
        step();
        mem_write = 1'b0;
        trace_ready = 1'b1;
        step();
        rand_write(5'd9);
        mips_cpu_reset = 1'b1;
        step();
        mips_cpu_reset = 1'b0;
        chk("mid_reset_valid", {31'd0, trace_valid}, 32'd0);
        chk("mid_reset_count", trace_count, 32'd0);
        chk("mid_reset_done", {31'd0, trace_done}, 32'd0);
        trace_ready = 1'b0;
        rand_write(5'd7);
        step();
        idle();
        chk("post_reset_count", trace_count, 32'd1);
        chk("post_reset_wnum", {27'd0, trace_wnum}, 32'd7);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
